uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between two byte sources.
- Local requester: the switch byte sent on a button press.
- Echo requester: bytes arriving from the UART receiver, sent back to the host.

Each source has its own small FIFO. A round-robin scheduler drains the FIFOs into the transmitter through a start/busy handshake and retries if the transmitter does not acknowledge. The block sits between the switch/button logic, the UART receiver, and the UART transmitter inside the UART subsystem.

---
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between the local switch byte source and the
// receiver echo path: two small FIFOs, round-robin grant, start/busy handshake with retry.
module uart_tx_arbiter #(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       loc_valid,
  input  logic [7:0] loc_data,
  output logic       loc_ready,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       last_grant,
  output logic [7:0] drop_count,
  output logic [1:0] fsm_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [7:0]    TO_LAST = 8'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t        state;
  logic [7:0]    to_cnt;

  logic [7:0]    loc_mem [DEPTH];
  logic [7:0]    ech_mem [DEPTH];
  logic [PW-1:0] loc_wr, loc_rd, ech_wr, ech_rd;
  logic [CW-1:0] loc_count, ech_count;

  logic loc_push, ech_push, loc_pop, ech_pop;
  logic loc_ne, ech_ne, ech_full;
  logic grant, grant_ech;

  // Fullness is judged on the registered count only, so a pop in the same
  // cycle never frees a slot for a simultaneous push.
  assign loc_ready = (loc_count != FULL);
  assign ech_full  = (ech_count == FULL);
  assign loc_push  = loc_valid && loc_ready;
  assign ech_push  = rx_valid && !ech_full;
  assign loc_ne    = (loc_count != '0);
  assign ech_ne    = (ech_count != '0);

  // No grant while the transmitter is still busy with a previous frame.
  assign grant     = (state == S_IDLE) && !tx_busy && (loc_ne || ech_ne);
  assign grant_ech = ech_ne && (!loc_ne || !last_grant);
  assign loc_pop   = grant && !grant_ech;
  assign ech_pop   = grant && grant_ech;

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (loc_push) loc_mem[loc_wr] <= loc_data;
    if (ech_push) ech_mem[ech_wr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      loc_wr     <= '0;
      loc_rd     <= '0;
      loc_count  <= '0;
      ech_wr     <= '0;
      ech_rd     <= '0;
      ech_count  <= '0;
      drop_count <= 8'h00;
      state      <= S_IDLE;
      to_cnt     <= 8'h00;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      last_grant <= 1'b1;
    end else begin
      if (loc_push) loc_wr <= loc_wr + PTR_ONE;
      if (loc_pop)  loc_rd <= loc_rd + PTR_ONE;
      loc_count <= loc_count + CW'(loc_push) - CW'(loc_pop);

      if (ech_push) ech_wr <= ech_wr + PTR_ONE;
      if (ech_pop)  ech_rd <= ech_rd + PTR_ONE;
      ech_count <= ech_count + CW'(ech_push) - CW'(ech_pop);

      if (rx_valid && ech_full && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;

      tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            tx_data    <= grant_ech ? ech_mem[ech_rd] : loc_mem[loc_rd];
            last_grant <= grant_ech;
            tx_start   <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: begin
          to_cnt <= 8'h00;
          state  <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (to_cnt + 8'd1 == TO_LAST) begin
            // Re-issue the same byte; tx_data is left untouched.
            tx_start <= 1'b1;
            state    <= S_START;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural transmitter model plus an in-order
// scoreboard of the bytes expected on tx_data at each tx_start pulse.
module tb_uart_tx_arbiter;

  localparam int DEPTH       = 4;
  localparam int ACK_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       loc_valid;
  logic [7:0] loc_data;
  logic       loc_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       last_grant;
  logic [7:0] drop_count;
  logic [1:0] fsm_state;

  uart_tx_arbiter #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .loc_valid  (loc_valid),
    .loc_data   (loc_data),
    .loc_ready  (loc_ready),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .last_grant (last_grant),
    .drop_count (drop_count),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int compares   = 0;
  int mismatches = 0;
  int pulse_cnt  = 0;
  int extra_cnt  = 0;
  logic [7:0] exp_q[$];
  logic sb_on;

  // transmitter model
  logic model_en;
  logic force_busy;
  int   busy_len;
  int   busy_cnt = 0;

  always @(posedge clk) begin
    if (model_en && tx_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0)    busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy || (busy_cnt > 0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compares++;
    if (got !== exp) begin
      mismatches++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      pulse_cnt++;
      if (sb_on) begin
        if (exp_q.size() > 0) check("tx_data", tx_data, exp_q.pop_front());
        else extra_cnt++;
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    extra_cnt = 0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic push_loc(input logic [7:0] d);
    int n = 0;
    loc_valid = 1'b1;
    loc_data  = d;
    while (!loc_ready && n < 200) begin
      tick(1);
      n++;
    end
    if (!loc_ready) check("loc_ready_wait", loc_ready, 1);
    tick(1);
    loc_valid = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && fsm_state == 2'd0 && !tx_busy) && n < budget) begin
      tick(1);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    check("extra_starts", extra_cnt, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0;
    int n;
    reset      = 1'b1;
    loc_valid  = 1'b0;
    loc_data   = 8'h00;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    force_busy = 1'b0;
    model_en   = 1'b1;
    busy_len   = 10;
    sb_on      = 1'b1;

    // 1: reset values, single local byte latency
    do_reset();
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_last_grant", last_grant, 1);
    check("rst_drop_count", drop_count, 0);
    check("rst_loc_ready", loc_ready, 1);
    check("rst_state", fsm_state, 0);
    p0 = pulse_cnt;
    exp_q.push_back(8'h41);
    loc_valid = 1'b1;
    loc_data  = 8'h41;
    tick(1);
    loc_valid = 1'b0;
    check("lat_e0_start", tx_start, 0);
    tick(1);
    check("lat_e1_start", tx_start, 1);
    check("lat_e1_data", tx_data, 8'h41);
    check("lat_e1_grant", last_grant, 0);
    wait_drain(100);
    check("single_idle", fsm_state, 0);
    check("single_pulses", pulse_cnt - p0, 1);

    // 2: contention, round robin starting with local
    do_reset();
    force_busy = 1'b1;
    busy_len   = 4;
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h32);
    exp_q.push_back(8'h62);
    p0 = pulse_cnt;
    push_loc(8'h31);
    push_loc(8'h32);
    pulse_rx(8'h61);
    pulse_rx(8'h62);
    tick(2);
    check("cont_held", pulse_cnt - p0, 0);
    force_busy = 1'b0;
    wait_drain(200);

    // 3: echo overflow and drop counter saturation
    do_reset();
    force_busy = 1'b1;
    for (int i = 1; i <= 7; i++) pulse_rx(8'(i));
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    check("drop_3", drop_count, 3);
    check("ovf_loc_ready", loc_ready, 1);
    for (int i = 0; i < 255; i++) pulse_rx(8'($urandom_range(0, 255)));
    check("drop_sat", drop_count, 255);
    force_busy = 1'b0;
    wait_drain(200);

    // 4: LOC full back-pressure
    do_reset();
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'hA0 + i));
    for (int i = 0; i < 4; i++) push_loc(8'(8'hA0 + i));
    check("full_ready", loc_ready, 0);
    loc_valid = 1'b1;
    loc_data  = 8'hA4;
    tick(3);
    check("full_hold_ready", loc_ready, 0);
    force_busy = 1'b0;
    tick(1);
    check("pop_frees_slot", loc_ready, 1);
    check("pop_start", tx_start, 1);
    tick(1);
    loc_valid = 1'b0;
    check("refull_ready", loc_ready, 0);
    wait_drain(300);

    // 5: ack timeout re-issue
    do_reset();
    sb_on    = 1'b0;
    model_en = 1'b0;
    push_loc(8'h5A);
    n = 0;
    while (!tx_start && n < 10) begin
      tick(1);
      n++;
    end
    check("to_first", tx_start, 1);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        tick(1);
        n++;
      end while (!tx_start && n < 100);
      check("to_period", n, ACK_TIMEOUT + 1);
      check("to_data", tx_data, 8'h5A);
    end
    force_busy = 1'b1;
    tick(1);
    p0 = pulse_cnt;
    tick(3 * (ACK_TIMEOUT + 1));
    check("to_busy_pulses", pulse_cnt - p0, 0);
    check("to_busy_state", fsm_state, 3);
    force_busy = 1'b0;
    tick(5);
    check("to_end_state", fsm_state, 0);
    check("to_end_pulses", pulse_cnt - p0, 0);

    // 6: reset during WAIT_DONE with bytes queued
    do_reset();
    sb_on    = 1'b1;
    model_en = 1'b1;
    busy_len = 30;
    exp_q.push_back(8'hB1);
    push_loc(8'hB1);
    n = 0;
    while (fsm_state != 2'd3 && n < 20) begin
      tick(1);
      n++;
    end
    check("wd_reached", fsm_state, 3);
    push_loc(8'hB2);
    pulse_rx(8'hC1);
    pulse_rx(8'hC2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    p0 = pulse_cnt;
    check("mid_rst_state", fsm_state, 0);
    check("mid_rst_ready", loc_ready, 1);
    check("mid_rst_drop", drop_count, 0);
    check("mid_rst_start", tx_start, 0);
    tick(40);
    check("mid_rst_pulses", pulse_cnt - p0, 0);
    check("mid_rst_idle", fsm_state, 0);

    // 7: random local stream with random busy lengths
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      busy_len = $urandom_range(1, 8);
      exp_q.push_back(d);
      push_loc(d);
    end
    wait_drain(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule
